// File: rtl/bsg_credit_to_ready_flow_converter.sv
// Credit-link receiver: buffers arriving words in a circular FIFO, serves them over valid/yumi
// and returns one credit per dequeue. Optional cut-through path: BSG_CREDIT_TO_READY_BYPASS_EN.
module bsg_credit_to_ready_flow_converter #(
  parameter int width_p = 8,
  parameter int els_p   = 50
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic               credit_o,
  output logic               overflow_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] cnt_full_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_n_s, rd_ptr_n_s;
  logic [cnt_w_lp-1:0] count_r, count_n_s;
  logic                fifo_v_r, credit_r, overflow_r;
  logic                full_s, deq_s, fifo_deq_s, enq_s, bypass_take_s, drop_s, v_s;
  logic [width_p-1:0]  data_s;

  // Depth need not be a power of two, so wrap by explicit compare
  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    if (p == ptr_last_lp) begin
      return ptr_w_lp'(0);
    end else begin
      return p + ptr_w_lp'(1);
    end
  endfunction

  // Consumer-facing head: FIFO state, or the arriving word when cut-through is built in
  always_comb begin
`ifdef BSG_CREDIT_TO_READY_BYPASS_EN
    v_s    = fifo_v_r | v_i;
    data_s = fifo_v_r ? mem_r[rd_ptr_r] : data_i;
`else
    v_s    = fifo_v_r;
    data_s = mem_r[rd_ptr_r];
`endif
  end

  // Handshake decode and next-state for pointers and occupancy
  always_comb begin
    full_s = (count_r == cnt_full_lp);
    deq_s  = yumi_i & v_s;
`ifdef BSG_CREDIT_TO_READY_BYPASS_EN
    bypass_take_s = deq_s & ~fifo_v_r;
`else
    bypass_take_s = 1'b0;
`endif
    fifo_deq_s = deq_s & ~bypass_take_s;
    enq_s      = v_i & (~full_s | deq_s) & ~bypass_take_s;
    drop_s     = v_i & full_s & ~deq_s;
    wr_ptr_n_s = enq_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
    rd_ptr_n_s = fifo_deq_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
    if (enq_s & ~fifo_deq_s) begin
      count_n_s = count_r + cnt_w_lp'(1);
    end else if (fifo_deq_s & ~enq_s) begin
      count_n_s = count_r - cnt_w_lp'(1);
    end else begin
      count_n_s = count_r;
    end
  end

  // Control state; a cut-through dequeue still earns a credit
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r   <= ptr_w_lp'(0);
      rd_ptr_r   <= ptr_w_lp'(0);
      count_r    <= cnt_w_lp'(0);
      fifo_v_r   <= 1'b0;
      credit_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_n_s;
      rd_ptr_r   <= rd_ptr_n_s;
      count_r    <= count_n_s;
      fifo_v_r   <= (count_n_s != cnt_w_lp'(0));
      credit_r   <= deq_s;
      overflow_r <= overflow_r | drop_s;
    end
  end

  // Storage is never cleared; contents are only meaningful under a valid count
  always_ff @(posedge clk_i) begin
    if (enq_s & ~reset_i) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  assign v_o        = v_s;
  assign data_o     = data_s;
  assign credit_o   = credit_r;
  assign overflow_o = overflow_r;

endmodule

// File: tb/tb_bsg_credit_to_ready_flow_converter.sv
// Scoreboard bench: a queue-based model predicts head/valid/overflow and the
// dequeued data and credit timing; a negedge monitor pops and compares.
module tb_bsg_credit_to_ready_flow_converter;

  localparam int ELS = 4;
  localparam int W   = 8;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         v_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         yumi_i = 1'b0;
  logic         v_o, credit_o, overflow_o;
  logic [W-1:0] data_o;

  bsg_credit_to_ready_flow_converter #(.width_p(W), .els_p(ELS)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .credit_o(credit_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [W-1:0] mq[$];
  logic         m_ovf = 1'b0;

  // Expectations handed to the monitor
  logic [W-1:0] exp_data_q[$];
  int           exp_credit_q[$];
  logic         exp_v_cur = 1'b0, exp_ovf_cur = 1'b0;
  logic [W-1:0] exp_head_cur = '0;
  bit           mon_en = 1'b0;

  int nchecks = 0;
  int nerrors = 0;
  int ndeq = 0;

  task automatic check(input string name, input int act, input int req);
    nchecks++;
    if (act != req) begin
      nerrors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  // One cycle of stimulus; yumi is only issued when the model says the head is valid
  task automatic step(input logic v, input logic [W-1:0] d, input logic y);
    logic ev, dq, byp;
    logic [W-1:0] hd;
    @(posedge clk); #1;
`ifdef BSG_CREDIT_TO_READY_BYPASS_EN
    ev = (mq.size() != 0) || v;
`else
    ev = (mq.size() != 0);
`endif
    hd  = (mq.size() != 0) ? mq[0] : d;
    dq  = y & ev;
    reset_i = 1'b0; v_i = v; data_i = d; yumi_i = dq;
    exp_v_cur = ev; exp_head_cur = hd; exp_ovf_cur = m_ovf;
    if (dq) begin
      exp_data_q.push_back(hd);
      exp_credit_q.push_back(cyc + 1);
      ndeq++;
    end
    if (v && mq.size() == ELS && !dq) begin
      m_ovf = 1'b1;
    end else begin
`ifdef BSG_CREDIT_TO_READY_BYPASS_EN
      byp = (mq.size() == 0) && dq;
`else
      byp = 1'b0;
`endif
      if (dq && !byp) void'(mq.pop_front());
      if (v && !byp) mq.push_back(d);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; data_i = W'($urandom);
      exp_v_cur = (i == 0) ? (mq.size() != 0) : 1'b0;
      exp_ovf_cur = (i == 0) ? m_ovf : 1'b0;
      exp_head_cur = (mq.size() != 0) ? mq[0] : '0;
      mq.delete();
      m_ovf = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  // Monitor: compare visible outputs against the expectations of the current cycle
  always @(negedge clk) begin
    if (mon_en) begin
      check("v_o", int'(v_o), int'(exp_v_cur));
      check("overflow_o", int'(overflow_o), int'(exp_ovf_cur));
      if (v_o && yumi_i) begin
        if (exp_data_q.size() == 0) begin
          check("unexpected_deq", 1, 0);
        end else begin
          check("deq_data", int'(data_o), int'(exp_data_q.pop_front()));
        end
      end else if (v_o && exp_v_cur) begin
        check("head_data", int'(data_o), int'(exp_head_cur));
      end
      if (credit_o) begin
        if (exp_credit_q.size() == 0) begin
          check("spurious_credit", 1, 0);
        end else begin
          check("credit_cycle", cyc, exp_credit_q.pop_front());
        end
      end else if (exp_credit_q.size() != 0 && exp_credit_q[0] <= cyc) begin
        check("missing_credit", 0, exp_credit_q.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b1;
    @(posedge clk); #1;
    exp_v_cur = 1'b0; exp_ovf_cur = 1'b0;
    mon_en = 1'b1;

    // Fill to full, no dequeue
    do_reset(2);
    for (int i = 0; i < ELS; i++) step(1'b1, W'(8'hA0 + i), 1'b0);
    idle(3);
    // Drain from full
    for (int i = 0; i < ELS; i++) step(1'b0, '0, 1'b1);
    idle(2);

    // Full with same-cycle enqueue and dequeue
    for (int i = 0; i < ELS; i++) step(1'b1, W'(8'hB0 + i), 1'b0);
    step(1'b1, 8'h55, 1'b1);
    for (int i = 0; i < ELS; i++) step(1'b0, '0, 1'b1);
    idle(2);

    // Full with enqueue only: dropped word, sticky overflow
    for (int i = 0; i < ELS; i++) step(1'b1, W'(8'hC0 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    idle(2);
    for (int i = 0; i < ELS; i++) step(1'b0, '0, 1'b1);
    idle(3);

    // Continuous streaming across pointer wraps
    do_reset(1);
    for (int i = 0; i < 20; i++) step(1'b1, W'(i), 1'b1);
    for (int i = 0; i < ELS; i++) step(1'b0, '0, 1'b1);
    idle(2);

    // Reset with three words stored
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'hD0 + i), 1'b0);
    do_reset(1);
    idle(2);

    // Cut-through when empty (only visible in the bypass build)
    step(1'b1, 8'h3C, 1'b1);
    idle(2);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
      end else begin
        step(($urandom_range(0, 99) < 60), W'($urandom), ($urandom_range(0, 99) < 55));
      end
    end
    idle(4);

    check("data_queue_drained", exp_data_q.size(), 0);
    check("credit_queue_drained", exp_credit_q.size(), 0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
